// File: rtl/readout_pkg.sv
// Shared types and constants for the timestamp readout path.
// Record layout is {tag, time[47:0]}, serialized most-significant word first.
package readout_pkg;

  localparam int unsigned WORDS_PER_REC = 4;
  localparam int unsigned WORD_W        = 16;
  localparam int unsigned TIME_W        = 48;
  localparam int unsigned REC_W         = 64;
  localparam int unsigned SEL_W         = $clog2(WORDS_PER_REC);

  typedef logic [SEL_W-1:0] wsel_t;

  // Word-select indices into a record, counted from the LSB word
  localparam wsel_t WSEL_TAG   = wsel_t'(3);
  localparam wsel_t WSEL_T_HI  = wsel_t'(2);
  localparam wsel_t WSEL_T_MID = wsel_t'(1);
  localparam wsel_t WSEL_T_LO  = wsel_t'(0);

  typedef struct packed {
    logic [WORD_W-1:0] tag;
    logic [TIME_W-1:0] ts;
  } rec_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W0,
    ST_W1,
    ST_W2,
    ST_W3
  } rd_state_e;

  function automatic logic [WORD_W-1:0] rec_word(input logic [REC_W-1:0] rec, input wsel_t sel);
    return rec[WORD_W*32'(sel) +: WORD_W];
  endfunction

endpackage

// File: rtl/readout_fifo.sv
// Single-clock record FIFO with registered count/full/empty.
// Exposes the head entry and the one behind it so the reader can chain records.
module readout_fifo
  import readout_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [REC_W-1:0] push_data,
  input  logic             pop,
  output logic [REC_W-1:0] head_c,
  output logic [REC_W-1:0] next_head_c,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [REC_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CW-1:0]    count_d;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    count_d = count;
    if (do_push && !do_pop)
      count_d = count + CW'(1);
    else if (do_pop && !do_push)
      count_d = count - CW'(1);
  end

  // Pointers wrap naturally; full/empty come from the count, not pointer compare
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_d;
      full  <= (count_d == CW'(DEPTH));
      empty <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_c      = mem[rd_ptr];
  assign next_head_c = mem[rd_ptr + AW'(1)];

endmodule

// File: rtl/timestamp_readout.sv
// Event timestamp capture, buffering and 16-bit MSB-first host serializer.
// Optional READOUT_DROP_CNT_EN adds a saturating drop counter reported in place of a tag.
module timestamp_readout
  import readout_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned TAG_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [TIME_W-1:0]        time_in,
  input  logic                     evt_valid,
  input  logic [TAG_W-1:0]         evt_tag,
  input  logic                     rd_en,
  output logic [WORD_W-1:0]        data_out,
  output logic                     data_valid,
  output logic [$clog2(DEPTH):0]   rec_count,
  output logic                     overflow
`ifdef READOUT_DROP_CNT_EN
  , output logic [15:0]            drop_cnt
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  rd_state_e        state_q, state_d;
  rec_t             cap_rec;
  logic [REC_W-1:0] head, next_head, load_rec, rec_q;
  logic [WORD_W-1:0] data_d;
  logic             valid_d;
  logic             cap, drop, pop, load, advance;
  logic             full, empty;
`ifdef READOUT_DROP_CNT_EN
  logic             drop_clr;
  logic [15:0]      drop_cnt_d;
`endif

  assign cap_rec = '{tag: evt_tag, ts: time_in};
  assign cap     = evt_valid & en & ~full;
  assign drop    = evt_valid & en & full;
  assign advance = rd_en & data_valid;

  readout_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (cap),
    .push_data   (cap_rec),
    .pop         (pop),
    .head_c      (head),
    .next_head_c (next_head),
    .count       (rec_count),
    .full        (full),
    .empty       (empty)
  );

  // Serializer next-state and next output word
  always_comb begin
    state_d  = state_q;
    data_d   = data_out;
    valid_d  = data_valid;
    pop      = 1'b0;
    load     = 1'b0;
    load_rec = head;
`ifdef READOUT_DROP_CNT_EN
    drop_clr = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          load    = 1'b1;
          state_d = ST_W0;
        end
      end
      ST_W0: if (advance) begin
        state_d = ST_W1;
        data_d  = rec_word(rec_q, WSEL_T_HI);
      end
      ST_W1: if (advance) begin
        state_d = ST_W2;
        data_d  = rec_word(rec_q, WSEL_T_MID);
      end
      ST_W2: if (advance) begin
        state_d = ST_W3;
        data_d  = rec_word(rec_q, WSEL_T_LO);
      end
      ST_W3: if (advance) begin
        pop = 1'b1;
        // Chain straight into the next record; a same-cycle capture is bypassed in
        if (rec_count > CW'(1)) begin
          load     = 1'b1;
          load_rec = next_head;
          state_d  = ST_W0;
        end else if (cap) begin
          load     = 1'b1;
          load_rec = cap_rec;
          state_d  = ST_W0;
        end else begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          data_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      valid_d = 1'b1;
      data_d  = rec_word(load_rec, WSEL_TAG);
`ifdef READOUT_DROP_CNT_EN
      if (drop_cnt != '0) begin
        data_d   = {1'b1, drop_cnt[14:0]};
        drop_clr = 1'b1;
      end
`endif
    end
  end

`ifdef READOUT_DROP_CNT_EN
  // A drop coinciding with the report starts the next tally at one
  always_comb begin
    drop_cnt_d = drop_cnt;
    if (drop_clr)
      drop_cnt_d = drop ? 16'd1 : 16'd0;
    else if (drop && drop_cnt != 16'hFFFF)
      drop_cnt_d = drop_cnt + 16'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rec_q      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
`ifdef READOUT_DROP_CNT_EN
      drop_cnt   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      data_out   <= data_d;
      data_valid <= valid_d;
      if (load) rec_q <= load_rec;
      if (drop) overflow <= 1'b1;
`ifdef READOUT_DROP_CNT_EN
      drop_cnt   <= drop_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_timestamp_readout.sv
// Directed bench for timestamp_readout with a word scoreboard.
// Exercises drop-counter reporting when READOUT_DROP_CNT_EN is defined.
module tb_timestamp_readout;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          en;
  logic [47:0]   time_in;
  logic          evt_valid;
  logic [15:0]   evt_tag;
  logic          rd_en;
  logic [15:0]   data_out;
  logic          data_valid;
  logic [CW-1:0] rec_count;
  logic          overflow;
`ifdef READOUT_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  logic [15:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  timestamp_readout #(.DEPTH(DEPTH), .TAG_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .time_in    (time_in),
    .evt_valid  (evt_valid),
    .evt_tag    (evt_tag),
    .rd_en      (rd_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .rec_count  (rec_count),
    .overflow   (overflow)
`ifdef READOUT_DROP_CNT_EN
    , .drop_cnt (drop_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Score the word consumed at the coming edge, then advance one cycle
  task automatic step();
    logic [15:0] e;
    if (data_valid && rd_en && !rst) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_extra observed=%0h expected=none", data_out);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("word", 64'(data_out), 64'(e));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_rec(input logic [15:0] tag, input logic [47:0] t);
    exp_q.push_back(tag);
    exp_q.push_back(t[47:32]);
    exp_q.push_back(t[31:16]);
    exp_q.push_back(t[15:0]);
  endtask

  task automatic send(input logic [15:0] tag, input logic [47:0] t, input bit exp_cap);
    evt_valid = 1'b1;
    evt_tag   = tag;
    time_in   = t;
    if (exp_cap) push_rec(tag, t);
    step();
    evt_valid = 1'b0;
  endtask

  task automatic drain(input int budget, output int cycles);
    rd_en  = 1'b1;
    cycles = 0;
    while (exp_q.size() != 0 && cycles < budget) begin
      step();
      cycles++;
    end
    chk("drain_done", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int c;
    rst = 1'b1; en = 1'b1; time_in = '0; evt_valid = 1'b0; evt_tag = '0; rd_en = 1'b0;
    @(negedge clk);
    step();
    step();
    chk("rst_data_out", 64'(data_out), 64'(0));
    chk("rst_valid", 64'(data_valid), 64'(0));
    chk("rst_count", 64'(rec_count), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    rst = 1'b0;
    step();

    // Single record, latency and word order
    rd_en = 1'b1;
    send(16'h0001, 48'h1234_5678_9ABC, 1'b1);
    chk("lat_valid_n1", 64'(data_valid), 64'(0));
    chk("lat_count_n1", 64'(rec_count), 64'(1));
    step();
    chk("lat_valid_n2", 64'(data_valid), 64'(1));
    chk("lat_word_n2", 64'(data_out), 64'(16'h0001));
    drain(10, c);
    chk("single_cycles", 64'(c), 64'(4));
    chk("single_count", 64'(rec_count), 64'(0));
    chk("single_valid", 64'(data_valid), 64'(0));

    // Fill to capacity, one overflow, ordered readback with no bubbles
    rd_en = 1'b0;
    for (int i = 0; i < 16; i++)
      send(16'h0100 + 16'(i), {16'hA000 + 16'(i), 32'hDEAD_0000 + 32'(i)}, 1'b1);
    chk("fill_count16", 64'(rec_count), 64'(16));
    chk("fill_ovf_pre", 64'(overflow), 64'(0));
    send(16'h0110, 48'hBEEF_0000_0000, 1'b0);
    chk("fill_count17", 64'(rec_count), 64'(16));
    chk("fill_ovf_post", 64'(overflow), 64'(1));
`ifdef READOUT_DROP_CNT_EN
    chk("fill_dropcnt", 64'(drop_cnt), 64'(1));
    exp_q[4] = 16'h8001;
`endif
    drain(100, c);
    chk("fill_drain_cycles", 64'(c), 64'(64));
    chk("fill_drain_count", 64'(rec_count), 64'(0));
    chk("fill_drain_valid", 64'(data_valid), 64'(0));

    // Capture on the cycle the last W3 word is popped
    rd_en = 1'b1;
    send(16'h0A0A, 48'h1111_2222_3333, 1'b1);
    step();
    step();
    step();
    step();
    chk("b2b_count_w3", 64'(rec_count), 64'(1));
    send(16'h0B0B, 48'h4444_5555_6666, 1'b1);
    chk("b2b_count", 64'(rec_count), 64'(1));
    chk("b2b_valid", 64'(data_valid), 64'(1));
    chk("b2b_word", 64'(data_out), 64'(16'h0B0B));
    drain(8, c);
    chk("b2b_cycles", 64'(c), 64'(4));
    chk("b2b_count_end", 64'(rec_count), 64'(0));

    // Reset mid-record discards everything, then a clean record
    rd_en = 1'b0;
    send(16'h0C01, 48'hAAAA_BBBB_CCCC, 1'b1);
    send(16'h0C02, 48'hDDDD_EEEE_FFFF, 1'b1);
    rd_en = 1'b1;
    step();
    step();
    chk("rstmid_count", 64'(rec_count), 64'(2));
    rd_en = 1'b0;
    rst   = 1'b1;
    exp_q.delete();
    step();
    rst = 1'b0;
    chk("rstmid_valid", 64'(data_valid), 64'(0));
    chk("rstmid_count0", 64'(rec_count), 64'(0));
    chk("rstmid_ovf", 64'(overflow), 64'(0));
    chk("rstmid_data", 64'(data_out), 64'(0));
    rd_en = 1'b1;
    send(16'h0D0D, 48'h0102_0304_0506, 1'b1);
    drain(12, c);
    chk("rstmid_cycles", 64'(c), 64'(5));

    // Capture disabled
    en = 1'b0;
    for (int i = 0; i < 3; i++)
      send(16'h0E00 + 16'(i), 48'h0000_0000_0100 + 48'(i), 1'b0);
    step();
    chk("en0_count", 64'(rec_count), 64'(0));
    chk("en0_valid", 64'(data_valid), 64'(0));
    chk("en0_ovf", 64'(overflow), 64'(0));
    en = 1'b1;

    // Fill then drop five events
    rd_en = 1'b0;
    for (int i = 0; i < 16; i++)
      send(16'h0200 + 16'(i), {16'h5000 + 16'(i), 32'h0BAD_0000 + 32'(i)}, 1'b1);
    for (int i = 0; i < 5; i++)
      send(16'h02F0 + 16'(i), 48'hFFFF_0000_0000, 1'b0);
    chk("drop_count", 64'(rec_count), 64'(16));
    chk("drop_ovf", 64'(overflow), 64'(1));
`ifdef READOUT_DROP_CNT_EN
    chk("drop_cnt5", 64'(drop_cnt), 64'(5));
    exp_q[4] = 16'h8005;
`endif
    drain(100, c);
    chk("drop_drain_count", 64'(rec_count), 64'(0));
`ifdef READOUT_DROP_CNT_EN
    chk("drop_cnt_clr", 64'(drop_cnt), 64'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
